// File: rtl/cdb_arbiter.sv
// cdb_arbiter: one-entry hold buffer per execution unit, one registered CDB broadcast per cycle.
// Build option: define CDB_RR_EN for round-robin arbitration; without it the lowest index always wins.
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 6,
  parameter int DATA_W  = 32,
  localparam int GW     = $clog2(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [NUM_REQ-1:0]        cdb_grant
);
  logic [NUM_REQ-1:0] hold_v_q, hold_v_d, gnt, accept;
  logic [TAG_W-1:0]   hold_tag_q [NUM_REQ];
  logic [DATA_W-1:0]  hold_data_q [NUM_REQ];
  logic [GW-1:0]      win;
  logic               any;
`ifdef CDB_RR_EN
  logic [GW-1:0]      ptr_q;
`endif
  // Pick one buffered entry: search from ptr+1 with wrap, or lowest index first
  always_comb begin
    gnt = '0;
    win = '0;
    any = 1'b0;
`ifdef CDB_RR_EN
    for (int k = 1; k <= NUM_REQ; k++)
      if (!any && hold_v_q[(int'(ptr_q) + k) % NUM_REQ]) begin
        any = 1'b1;
        win = GW'((int'(ptr_q) + k) % NUM_REQ);
      end
`else
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (hold_v_q[i]) begin
        any = 1'b1;
        win = GW'(i);
      end
`endif
    if (any) gnt[win] = 1'b1;
  end
  // A winner's slot frees up in the same cycle so a streaming unit never bubbles
  assign req_ready = (i_rst_n && !flush) ? (~hold_v_q | gnt) : '0;
  assign accept    = req_valid & req_ready;
  assign hold_v_d  = (hold_v_q & ~gnt) | accept;
  // Buffer valids, registered broadcast and priority pointer; flush beats everything
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n || flush) begin
      hold_v_q  <= '0;
      cdb_valid <= 1'b0;
      cdb_grant <= '0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
`ifdef CDB_RR_EN
      ptr_q     <= GW'(NUM_REQ - 1);
`endif
    end else begin
      hold_v_q  <= hold_v_d;
      cdb_valid <= any;
      cdb_grant <= gnt;
      cdb_tag   <= any ? hold_tag_q[win] : '0;
      cdb_data  <= any ? hold_data_q[win] : '0;
`ifdef CDB_RR_EN
      if (any) ptr_q <= win;
`endif
    end
  // Payload capture; contents only matter while the matching valid bit is set
  always_ff @(posedge i_clk)
    for (int i = 0; i < NUM_REQ; i++)
      if (accept[i]) begin
        hold_tag_q[i]  <= req_tag[i*TAG_W +: TAG_W];
        hold_data_q[i] <= req_data[i*DATA_W +: DATA_W];
      end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: vector table plus scoreboard queue, with hand-written reset/latency sequences.
module tb_cdb_arbiter;
  logic         i_clk = 1'b0, i_rst_n = 1'b0, flush = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [23:0]  req_tag = '0;
  logic [127:0] req_data = '0;
  logic [3:0]   req_ready, cdb_grant;
  logic         cdb_valid;
  logic [5:0]   cdb_tag;
  logic [31:0]  cdb_data;
  int errs = 0, checks = 0;
  typedef struct {
    logic       fl;
    logic [3:0] v;
    logic [23:0] tags;
    logic [3:0] rdy;
    logic       cv;
    logic [3:0] g;
    logic [5:0] tag;
  } vec_t;
  typedef struct {
    logic       cv;
    logic [3:0] g;
    logic [5:0] tag;
    logic [31:0] d;
  } exp_t;
  vec_t vecs[$];
  exp_t sb[$];
  cdb_arbiter dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .flush(flush),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
    .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_grant(cdb_grant)
  );
  always #5 i_clk = ~i_clk;
  function automatic logic [31:0] fdat(input int u, input logic [5:0] t);
    return {4'hA, 4'(u), 18'h0, t};
  endfunction
  function automatic int oh2i(input logic [3:0] g);
    int r = 0;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic fl, input logic [3:0] v, input logic [23:0] tags);
    flush = fl;
    req_valid = v;
    req_tag = tags;
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = fdat(i, tags[i*6 +: 6]);
  endtask
  task automatic add(input int fl, input int v, input int t0, input int t1, input int t2,
                     input int t3, input int rdy, input int cv, input int g, input int tag);
    vecs.push_back('{1'(fl), 4'(v), {6'(t3), 6'(t2), 6'(t1), 6'(t0)}, 4'(rdy), 1'(cv), 4'(g), 6'(tag)});
  endtask
  initial begin
    exp_t e;
`ifdef CDB_RR_EN
    add(0, 'b1111, 1, 2, 3, 4, 'hF,   0, 0,      0);
    add(0, 0,      0, 0, 0, 0, 'b0001, 1, 'b0001, 1);
    add(0, 0,      0, 0, 0, 0, 'b0011, 1, 'b0010, 2);
    add(0, 0,      0, 0, 0, 0, 'b0111, 1, 'b0100, 3);
    add(0, 0,      0, 0, 0, 0, 'hF,   1, 'b1000, 4);
    add(0, 0,      0, 0, 0, 0, 'hF,   0, 0,      0);
    add(0, 'b0101, 10, 0, 11, 0, 'hF,   0, 0,      0);
    add(0, 'b0101, 12, 0, 13, 0, 'b1011, 1, 'b0001, 10);
    add(0, 'b0101, 14, 0, 13, 0, 'b1110, 1, 'b0100, 11);
    add(0, 'b0101, 14, 0, 15, 0, 'b1011, 1, 'b0001, 12);
    add(0, 'b0101, 16, 0, 15, 0, 'b1110, 1, 'b0100, 13);
    add(0, 0,      0, 0, 0, 0, 'b1011, 1, 'b0001, 14);
    add(0, 0,      0, 0, 0, 0, 'hF,   1, 'b0100, 15);
    add(0, 0,      0, 0, 0, 0, 'hF,   0, 0,      0);
`else
    add(0, 'b0001, 1, 0, 0, 0, 'hF,   0, 0,      0);
    add(0, 'b1001, 2, 0, 0, 3, 'hF,   1, 'b0001, 1);
    add(0, 'b1001, 4, 0, 0, 5, 'b0111, 1, 'b0001, 2);
    add(0, 'b1001, 6, 0, 0, 5, 'b0111, 1, 'b0001, 4);
    add(0, 0,      0, 0, 0, 0, 'b0111, 1, 'b0001, 6);
    add(0, 0,      0, 0, 0, 0, 'hF,   1, 'b1000, 3);
    add(0, 0,      0, 0, 0, 0, 'hF,   0, 0,      0);
`endif
    add(0, 'b1010, 0, 7, 0, 8, 'hF,   0, 0,      0);
    add(1, 'b0001, 9, 0, 0, 0, 'h0,   0, 0,      0);
    add(0, 0,      0, 0, 0, 0, 'hF,   0, 0,      0);
    add(0, 0,      0, 0, 0, 0, 'hF,   0, 0,      0);
    add(0, 'b1001, 10, 0, 0, 0, 'hF,  0, 0,      0);
    add(0, 0,      0, 0, 0, 0, 'b0111, 1, 'b0001, 10);
    add(0, 0,      0, 0, 0, 0, 'hF,   1, 'b1000, 0);
    add(0, 0,      0, 0, 0, 0, 'hF,   0, 0,      0);
    drive(0, 4'hF, 24'h123456);
    repeat (3) @(posedge i_clk);
    #1 chk("rst_ready", 64'(req_ready), 0);
    chk("rst_cdb", {cdb_valid, cdb_grant}, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    drive(0, 0, 0);
    #1 chk("ready_after_rst", 64'(req_ready), 64'hF);
    @(negedge i_clk);
    drive(0, 4'b0010, {12'h0, 6'h05, 6'h0});
    req_data[63:32] = 32'hDEADBEEF;
    @(posedge i_clk);
    #1 chk("single_capture_only", 64'(cdb_valid), 0);
    @(negedge i_clk);
    drive(0, 0, 0);
    @(posedge i_clk);
    #1 chk("single_bcast", {cdb_valid, cdb_grant, cdb_tag, cdb_data}, {1'b1, 4'b0010, 6'h05, 32'hDEADBEEF});
    @(posedge i_clk);
    #1 chk("single_once", {cdb_valid, cdb_grant}, 0);
    @(negedge i_clk);
    drive(0, 4'b0011, {12'h0, 6'h22, 6'h21});
    @(posedge i_clk);
    @(negedge i_clk);
    drive(0, 0, 0);
    @(posedge i_clk);
    #1 chk("pre_async_rst", {cdb_valid, cdb_grant, cdb_tag}, {1'b1, 4'b0001, 6'h21});
    #2 i_rst_n = 1'b0;
    #1 chk("async_rst_cdb", {cdb_valid, cdb_grant, cdb_tag, cdb_data}, 0);
    chk("async_rst_ready", 64'(req_ready), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge i_clk);
      #1 chk($sformatf("discard_%0d", i), 64'(cdb_valid), 0);
    end
    foreach (vecs[i]) begin
      @(negedge i_clk);
      drive(vecs[i].fl, vecs[i].v, vecs[i].tags);
      sb.push_back('{vecs[i].cv, vecs[i].g, vecs[i].tag,
                     vecs[i].cv ? fdat(oh2i(vecs[i].g), vecs[i].tag) : 32'h0});
      #1 chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(vecs[i].rdy));
      @(posedge i_clk);
      #1 e = sb.pop_front();
      chk($sformatf("v%0d_cdb", i), {cdb_valid, cdb_grant, cdb_tag, cdb_data}, {e.cv, e.g, e.tag, e.d});
    end
    drive(0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates the common data bus (CDB) among the execution units (ALU, load/store, multiplier, divider) that complete out of order.
- Each unit hands its result (tag + data) to a one-entry hold buffer inside this block.
- The arbiter picks one buffered result per cycle and drives the registered CDB broadcast. That broadcast is consumed by the reservation stations, the register status table and the ROB.
- Units stall through a per-requester ready, so no result is ever lost.

Parameters:
- NUM_REQ, 4, number of execution units sharing the CDB; GW = $clog2(NUM_REQ).
- TAG_W, 6, ROB/physical tag width.
- DATA_W, 32, result data width.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous pipeline flush (branch mispredict).
- req_valid  input  NUM_REQ  per-unit result valid.
- req_tag  input  NUM_REQ*TAG_W  packed tags; unit i at [i*TAG_W +: TAG_W].
- req_data  input  NUM_REQ*DATA_W  packed results; unit i at [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  hold buffer i can accept this cycle.
- cdb_valid  output  1  broadcast valid (registered).
- cdb_tag  output  TAG_W  broadcast tag (registered).
- cdb_data  output  DATA_W  broadcast data (registered).
- cdb_grant  output  NUM_REQ  one-hot source of the current broadcast (registered).

Behaviour:
- Reset (async): all hold buffers invalid; cdb_valid/tag/data/grant = 0; RR pointer = NUM_REQ-1, so unit 0 has first priority. req_ready = 0 while i_rst_n is low.
- Hold buffer i accepts {tag, data} at the clock edge where req_valid[i] && req_ready[i]. The captured entry is eligible for arbitration in the following cycle.
- req_ready[i] = !hold_v[i] || gnt[i], where gnt is the combinational arbiter result for the current cycle.
  - This gives same-cycle dequeue and enqueue: a continuously requesting unit sustains one result per cycle when it wins.
  - req_ready = 0 whenever flush = 1.
- Arbitration each cycle covers all hold_v[i]. Round-robin: search starts at (ptr+1) mod NUM_REQ and wraps. The pointer updates to the winner index only when a grant occurs; with no grant it holds.
- On a grant at an edge:
  - cdb_valid <= 1, cdb_tag/cdb_data <= winner entry, cdb_grant <= one-hot winner.
  - hold_v[winner] cleared, unless it is refilled the same edge.
- No grant: cdb_valid <= 0, cdb_grant <= 0, cdb_tag/cdb_data <= 0.
- Latency: request at edge E0 -> cdb_valid high for exactly one cycle after edge E1 (minimum). Each broadcast lasts one cycle; no result is broadcast twice.
- At most one broadcast per cycle; non-winning buffered entries wait with contents unchanged.
- Flush (synchronous, highest priority):
  - At the edge: all hold_v cleared, cdb_valid/grant/tag/data <= 0, ptr <= NUM_REQ-1.
  - Inputs presented in the flush cycle are dropped.
- Reset asserted mid-broadcast: outputs go to 0 immediately (async); all pending entries are discarded.
- Tag value 0 carries no special meaning here; it is forwarded like any other tag.

Optional Feature:
- CDB_RR_EN defined: round-robin arbitration as above.
- CDB_RR_EN undefined: fixed priority, lowest index wins. The pointer register is not instantiated. A lower-index unit requesting every cycle can starve higher-index units indefinitely; this is intended for a single-ALU bring-up configuration.

Test Plan:
- Reset: hold i_rst_n low 3 cycles -> req_ready = 4'h0, cdb_valid = 0, cdb_grant = 0; release -> req_ready = 4'hF on the first cycle.
- Single result: req_valid = 4'b0010, tag 6'h05, data 32'hDEADBEEF for one cycle -> after the next edge cdb_valid = 1, cdb_tag = 6'h05, cdb_data = 32'hDEADBEEF, cdb_grant = 4'b0010 for one cycle, then cdb_valid = 0.
- Contention (CDB_RR_EN): all 4 units present tags 1..4 in the same cycle -> cdb_grant 0001, 0010, 0100, 1000 on four consecutive cycles with no bubbles. Tags 1, 2, 3, 4 appear in order.
- Sustained pair (CDB_RR_EN): units 0 and 2 request every cycle with incrementing tags -> grants alternate 0001/0100; each unit's req_ready is high exactly in its grant cycles; no tag lost or duplicated.
- Flush: units 1 and 3 buffered, unit 0 presenting, flush = 1 one cycle -> cdb_valid = 0 on every following cycle until new requests arrive; the dropped tags are never broadcast.
- Fixed priority (CDB_RR_EN undefined): units 0 and 3 request every cycle -> cdb_grant = 0001 every cycle; req_ready[3] stays 0 after its first capture.
